// File: rtl/uart_ascii_dec2bin.sv
// Decimal ASCII entry parser: accumulates digits from a UART RX byte stream and
// publishes the unsigned WIDTH-bit value on CR/LF, flagging rejected entries.
module uart_ascii_dec2bin #(
    parameter int WIDTH      = 8,
    parameter int MAX_DIGITS = 3,
    parameter int TIMEOUT    = 0,
    localparam int CW        = $clog2(MAX_DIGITS + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_valid,
    output logic [WIDTH-1:0] o_value,
    output logic             o_value_valid,
    output logic             o_err,
    output logic             o_busy,
    output logic [CW-1:0]    o_digit_count,
    output logic [1:0]       o_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCUM   = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    localparam bit            TO_EN = (TIMEOUT > 0);
    localparam int            TW    = TO_EN ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TLAST = TO_EN ? TW'(TIMEOUT - 1) : '0;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH+3:0]   r_acc;
    logic [CW-1:0]      r_count;
    logic [TW-1:0]      r_timer;
    logic [WIDTH-1:0]   r_value;
    logic               r_value_valid;
    logic               r_err;

    logic               w_is_digit;
    logic               w_is_term;
    logic               w_is_esc;
    logic [3:0]         w_d;
    logic [WIDTH+3:0]   w_nxt;
    logic               w_ovf;
    logic               w_full;
    logic               w_expire;
    logic               w_publish;
    logic               w_reject;

    assign w_is_digit = (i_rx_data >= 8'h30) && (i_rx_data <= 8'h39);
    assign w_is_term  = (i_rx_data == 8'h0D) || (i_rx_data == 8'h0A);
    assign w_is_esc   = (i_rx_data == 8'h1B);
    assign w_d        = i_rx_data[3:0];

    // acc never exceeds 2^WIDTH-1 while accumulating, so acc*10+9 fits in WIDTH+4 bits.
    assign w_nxt  = (r_acc << 3) + (r_acc << 1) + {{WIDTH{1'b0}}, w_d};
    assign w_ovf  = |w_nxt[WIDTH+3:WIDTH];
    assign w_full = (r_count == CW'(MAX_DIGITS));

    // A strobe in the expiry cycle takes priority over the timeout.
    assign w_expire = TO_EN && (r_state == S_ACCUM) && !i_rx_valid && (r_timer == TLAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_rx_valid) begin
                    if (w_is_digit) begin
                        w_state_nxt = S_ACCUM;
                    end else if (!w_is_term && !w_is_esc) begin
                        w_state_nxt = S_DISCARD;
                    end
                end
            end
            S_ACCUM: begin
                if (i_rx_valid) begin
                    if (w_is_digit) begin
                        if (w_full || w_ovf) begin
                            w_state_nxt = S_DISCARD;
                        end
                    end else if (w_is_term || w_is_esc) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DISCARD;
                    end
                end else if (w_expire) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DISCARD: begin
                if (i_rx_valid && (w_is_term || w_is_esc)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_publish     = (r_state == S_ACCUM) && i_rx_valid && w_is_term;
        w_reject      = ((r_state == S_DISCARD) && i_rx_valid && w_is_term) || w_expire;
        o_busy        = (r_state != S_IDLE);
        o_digit_count = (r_state == S_ACCUM) ? r_count : '0;
        o_state       = r_state;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc   <= '0;
            r_count <= '0;
        end else if (w_state_nxt != S_ACCUM) begin
            r_acc   <= '0;
            r_count <= '0;
        end else if (r_state == S_IDLE) begin
            r_acc   <= {{WIDTH{1'b0}}, w_d};
            r_count <= CW'(1);
        end else if (i_rx_valid && w_is_digit) begin
            r_acc   <= w_nxt;
            r_count <= r_count + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || !TO_EN || i_rx_valid || (w_state_nxt != S_ACCUM)) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_value       <= '0;
            r_value_valid <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_value_valid <= w_publish;
            r_err         <= w_reject;
            if (w_publish) begin
                r_value <= r_acc[WIDTH-1:0];
            end
        end
    end

    assign o_value       = r_value;
    assign o_value_valid = r_value_valid;
    assign o_err         = r_err;

endmodule

// File: tb/tb_uart_ascii_dec2bin.sv
// Bench for uart_ascii_dec2bin: one byte stream feeds an 8-bit/TIMEOUT=50 instance (a)
// and a 16-bit/no-timeout instance (b); pulses are scoreboarded against expected queues.
module tb_uart_ascii_dec2bin;

    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] LF  = 8'h0A;
    localparam logic [7:0] ESC = 8'h1B;
    localparam logic [1:0] K_VAL = 2'd1;
    localparam logic [1:0] K_ERR = 2'd2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;

    logic [7:0]  a_value;
    logic        a_vv, a_err, a_busy;
    logic [1:0]  a_dc, a_state;
    logic [15:0] b_value;
    logic        b_vv, b_err, b_busy;
    logic [1:0]  b_dc, b_state;

    int total = 0;
    int bad   = 0;

    // entries are {kind, value}; an err entry carries the value that must still be held
    logic [17:0] exp_a[$];
    logic [17:0] exp_b[$];
    logic [15:0] hv_a = '0;
    logic [15:0] hv_b = '0;

    uart_ascii_dec2bin #(.WIDTH(8), .MAX_DIGITS(3), .TIMEOUT(50)) u_a (
        .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_value(a_value), .o_value_valid(a_vv), .o_err(a_err), .o_busy(a_busy),
        .o_digit_count(a_dc), .o_state(a_state)
    );

    uart_ascii_dec2bin #(.WIDTH(16), .MAX_DIGITS(3), .TIMEOUT(0)) u_b (
        .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_value(b_value), .o_value_valid(b_vv), .o_err(b_err), .o_busy(b_busy),
        .o_digit_count(b_dc), .o_state(b_state)
    );

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin : mon
        logic [17:0] e;
        logic [17:0] got;
        if (a_vv || a_err) begin
            total++;
            got = {(a_err ? K_ERR : K_VAL), 8'h00, a_value};
            if (a_vv && a_err) begin
                bad++;
                $display("FAIL a_pulse_overlap got vv=%0b err=%0b required exclusive", a_vv, a_err);
            end else if (exp_a.size() == 0) begin
                bad++;
                $display("FAIL a_unexpected_pulse got kind=%0d value=%0d required none", got[17:16], got[15:0]);
            end else begin
                e = exp_a.pop_front();
                if (got !== e) begin
                    bad++;
                    $display("FAIL a_pulse got kind=%0d value=%0d required kind=%0d value=%0d",
                             got[17:16], got[15:0], e[17:16], e[15:0]);
                end
            end
        end
        if (b_vv || b_err) begin
            total++;
            got = {(b_err ? K_ERR : K_VAL), b_value};
            if (b_vv && b_err) begin
                bad++;
                $display("FAIL b_pulse_overlap got vv=%0b err=%0b required exclusive", b_vv, b_err);
            end else if (exp_b.size() == 0) begin
                bad++;
                $display("FAIL b_unexpected_pulse got kind=%0d value=%0d required none", got[17:16], got[15:0]);
            end else begin
                e = exp_b.pop_front();
                if (got !== e) begin
                    bad++;
                    $display("FAIL b_pulse got kind=%0d value=%0d required kind=%0d value=%0d",
                             got[17:16], got[15:0], e[17:16], e[15:0]);
                end
            end
        end
    end

    // ---------------- expectation pushes ----------------
    task automatic exp_val_a(input logic [15:0] v);
        hv_a = v;
        exp_a.push_back({K_VAL, v});
    endtask

    task automatic exp_val_b(input logic [15:0] v);
        hv_b = v;
        exp_b.push_back({K_VAL, v});
    endtask

    task automatic exp_err_a();
        exp_a.push_back({K_ERR, hv_a});
    endtask

    task automatic exp_err_b();
        exp_b.push_back({K_ERR, hv_b});
    endtask

    // ---------------- drivers ----------------
    // Each driver call ends 1 time unit after a rising edge.
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_num(input int n);
        if (n >= 100) send(8'h30 + 8'(n / 100));
        if (n >= 10)  send(8'h30 + 8'((n / 10) % 10));
        send(8'h30 + 8'(n % 10));
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        idle(3);
        total++;
        if ({a_value, a_vv, a_err, a_busy, a_dc} !== 13'd0) begin
            bad++;
            $display("FAIL reset_a got value=%0d vv=%0b err=%0b busy=%0b dc=%0d required all 0",
                     a_value, a_vv, a_err, a_busy, a_dc);
        end
        total++;
        if ({b_value, b_vv, b_err, b_busy, b_dc} !== 21'd0) begin
            bad++;
            $display("FAIL reset_b got value=%0d vv=%0b err=%0b busy=%0b dc=%0d required all 0",
                     b_value, b_vv, b_err, b_busy, b_dc);
        end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_basic();
        send("1");
        total++;
        if (a_busy !== 1'b1 || b_busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_after_digit got a=%0b b=%0b required 1", a_busy, b_busy);
        end
        send("2");
        send("3");
        total++;
        if (a_dc !== 2'd3 || b_dc !== 2'd3) begin
            bad++;
            $display("FAIL count_123 got a=%0d b=%0d required 3", a_dc, b_dc);
        end
        exp_val_a(16'd123);
        exp_val_b(16'd123);
        send(CR);
        total++;
        if (a_vv !== 1'b1 || a_value !== 8'd123 || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL latency_123 got vv=%0b value=%0d busy=%0b required vv=1 value=123 busy=0",
                     a_vv, a_value, a_busy);
        end
        idle(1);
        total++;
        if (a_vv !== 1'b0 || b_vv !== 1'b0) begin
            bad++;
            $display("FAIL pulse_width got a=%0b b=%0b required 0", a_vv, b_vv);
        end
        idle(2);
    endtask

    task automatic test_overflow();
        send("2"); send("5"); send("6");
        exp_err_a();
        exp_val_b(16'd256);
        send(CR);
        idle(2);
        total++;
        if (a_value !== 8'd123) begin
            bad++;
            $display("FAIL ovf_value_held got %0d required 123", a_value);
        end
        send("2"); send("5"); send("5");
        exp_val_a(16'd255);
        exp_val_b(16'd255);
        send(CR);
        idle(2);
    endtask

    task automatic test_too_many();
        send("1"); send("2"); send("3"); send("4");
        total++;
        if (a_dc !== 2'd0 || b_dc !== 2'd0 || b_busy !== 1'b1) begin
            bad++;
            $display("FAIL discard_count got a=%0d b=%0d busy=%0b required 0 0 1", a_dc, b_dc, b_busy);
        end
        exp_err_a();
        exp_err_b();
        send(CR);
        idle(2);
        send("0"); send("0"); send("7");
        total++;
        if (a_dc !== 2'd3 || b_dc !== 2'd3) begin
            bad++;
            $display("FAIL count_007 got a=%0d b=%0d required 3", a_dc, b_dc);
        end
        exp_val_a(16'd7);
        exp_val_b(16'd7);
        send(CR);
        idle(2);
    endtask

    task automatic test_terms();
        send(CR); send(LF); send(ESC);
        idle(2);
        send("9");
        exp_val_a(16'd9);
        exp_val_b(16'd9);
        send(CR); send(LF);
        idle(2);
        send("4"); send(ESC);
        total++;
        if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
            bad++;
            $display("FAIL esc_to_idle got a=%0b b=%0b required 0", a_busy, b_busy);
        end
        send("5");
        exp_val_a(16'd5);
        exp_val_b(16'd5);
        send(CR);
        idle(2);
        send("1"); send("x"); send("2");
        exp_err_a();
        exp_err_b();
        send(CR);
        idle(2);
        total++;
        if (a_value !== 8'd5 || b_value !== 16'd5) begin
            bad++;
            $display("FAIL badchar_value_held got a=%0d b=%0d required 5", a_value, b_value);
        end
        send("x"); send(ESC);
        idle(2);
        send("?");
        exp_err_a();
        exp_err_b();
        send(CR);
        idle(2);
    endtask

    task automatic test_timeout();
        send("8");
        exp_err_a();
        idle(49);
        total++;
        if (a_busy !== 1'b1 || a_err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_early got busy=%0b err=%0b required 1 0", a_busy, a_err);
        end
        idle(1);
        total++;
        if (a_busy !== 1'b0 || a_err !== 1'b1 || b_busy !== 1'b1) begin
            bad++;
            $display("FAIL timeout_fire got a_busy=%0b a_err=%0b b_busy=%0b required 0 1 1",
                     a_busy, a_err, b_busy);
        end
        exp_val_b(16'd8);
        send(CR);
        idle(2);
        send("8");
        idle(48);
        send("2");
        exp_val_a(16'd82);
        exp_val_b(16'd82);
        send(CR);
        idle(2);
        send("8");
        idle(49);
        send("3");
        total++;
        if (a_busy !== 1'b1) begin
            bad++;
            $display("FAIL timeout_race got busy=%0b required 1", a_busy);
        end
        exp_val_a(16'd83);
        exp_val_b(16'd83);
        send(CR);
        idle(2);
    endtask

    task automatic test_reset_mid();
        send("4");
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        hv_a = '0;
        hv_b = '0;
        send(CR);
        idle(2);
        total++;
        if (a_value !== 8'd0 || b_value !== 16'd0 || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid got a=%0d b=%0d busy=%0b required 0 0 0", a_value, b_value, a_busy);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        send("1"); send("2");
        exp_val_a(16'd12);
        exp_val_b(16'd12);
        send(CR);
        for (int i = 0; i < 8; i++) begin
            n = $urandom_range(0, 255);
            send_num(n);
            exp_val_a(16'(n));
            exp_val_b(16'(n));
            send(LF);
        end
        idle(3);
        total++;
        if (b_value !== hv_b) begin
            bad++;
            $display("FAIL b2b_last_value got %0d required %0d", b_value, hv_b);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_too_many();
        test_terms();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        idle(3);
        total++;
        if (exp_a.size() != 0) begin
            bad++;
            $display("FAIL a_missing_pulses got pending=%0d required 0", exp_a.size());
        end
        total++;
        if (exp_b.size() != 0) begin
            bad++;
            $display("FAIL b_missing_pulses got pending=%0d required 0", exp_b.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
